// File: rtl/hazard_scoreboard_pkg.sv
// ============================================================================
// Module      : hazard_scoreboard_pkg
// Description : Shared definitions for the hazard scoreboard. These include
//               the D-stage forwarding select codes, the default field widths
//               and the MDU latencies, and a small helper for sizing the
//               MDU busy counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_scoreboard_pkg;

  // D-stage forwarding source: register file or the stage holding the value
  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_E  = 2'd1,
    FWD_M  = 2'd2,
    FWD_W  = 2'd3
  } fwd_sel_e;

  localparam int AW_DEF      = 5;
  localparam int TW_DEF      = 2;
  localparam int NSTG_DEF    = 3;
  localparam int MUL_LAT_DEF = 5;
  localparam int DIV_LAT_DEF = 10;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_slot_cmp.sv
// ============================================================================
// Module      : hazard_slot_cmp
// Description : Compares one scoreboard slot against one D-stage source
//               operand. The outputs are the address match (register 0
//               never matches), whether the producer is still too late for
//               the consumer (tnew > tuse), and whether the producer value is
//               already available (tnew == 0).
// Ports       : i_valid/i_a3/i_tnew - slot contents
//               i_reg/i_tuse        - operand address and its Tuse
//               o_match, o_late, o_ready
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_slot_cmp #(
  parameter int AW = 5,
  parameter int TW = 2
) (
  input  logic          i_valid,
  input  logic [AW-1:0] i_a3,
  input  logic [TW-1:0] i_tnew,
  input  logic [AW-1:0] i_reg,
  input  logic [TW-1:0] i_tuse,
  output logic          o_match,
  output logic          o_late,
  output logic          o_ready
);

  assign o_match = i_valid && (i_a3 == i_reg) && (i_reg != '0);
  assign o_late  = (i_tnew > i_tuse);
  assign o_ready = (i_tnew == '0);

endmodule

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
// ============================================================================
// Module      : hazard_scoreboard
// Description : Stall/forward controller for the in-order F/D/E/M/W pipeline.
//               In-flight register writes are tracked in a Tnew shift chain
//               (slot 0 = E, slot 1 = M, slot 2 = W). A busy counter models
//               the multi-cycle mult/div unit.
// Ports       : clk, reset (async, active-high)
//               i_d_rs/i_d_rs_use/i_d_tuse_rs - D rs operand
//               i_d_rt/i_d_rt_use/i_d_tuse_rt - D rt operand
//               i_d_a3/i_d_tnew               - D destination and its Tnew
//               i_d_md_start/i_d_md_div/i_d_md_use - MDU control from D
//               o_fd_stall, o_de_bubble      - hold F/D, bubble D/E
//               o_fwd_rs, o_fwd_rt            - D forward select (0 RF,1 E,2 M,3 W)
//               o_md_busy                     - MDU running or start in E
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int TW      = TW_DEF,
  parameter int NSTG    = NSTG_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] i_d_rs,
  input  logic          i_d_rs_use,
  input  logic [TW-1:0] i_d_tuse_rs,
  input  logic [AW-1:0] i_d_rt,
  input  logic          i_d_rt_use,
  input  logic [TW-1:0] i_d_tuse_rt,
  input  logic [AW-1:0] i_d_a3,
  input  logic [TW-1:0] i_d_tnew,
  input  logic          i_d_md_start,
  input  logic          i_d_md_div,
  input  logic          i_d_md_use,
  output logic          o_fd_stall,
  output logic          o_de_bubble,
  output logic [1:0]    o_fwd_rs,
  output logic [1:0]    o_fwd_rt,
  output logic          o_md_busy
);

  localparam int C_MAX_LAT = max_int(MUL_LAT, DIV_LAT);
  localparam int C_CW      = $clog2(C_MAX_LAT + 1);

  // --------------------------------------------------------------------------
  // Scoreboard slots
  // --------------------------------------------------------------------------
  logic [NSTG-1:0] r_valid;
  logic [AW-1:0]   r_a3   [NSTG];
  logic [TW-1:0]   r_tnew [NSTG];

  // Per-slot compare results for each operand
  logic [NSTG-1:0] w_rs_match, w_rs_late, w_rs_ready;
  logic [NSTG-1:0] w_rt_match, w_rt_late, w_rt_ready;

  // MDU state
  logic [C_CW-1:0] r_md_cnt;
  logic            r_md_start_e;

  logic            w_stall;
  logic            w_data_stall;
  logic            w_md_stall;
  logic            w_md_accept;
  logic            w_md_busy;
  logic            w_rs_late_sel;
  logic            w_rt_late_sel;
  logic            w_rs_hit;
  logic            w_rt_hit;
  logic [1:0]      w_fwd_rs;
  logic [1:0]      w_fwd_rt;

  generate
    for (genvar k = 0; k < NSTG; k++) begin : g_slot
      hazard_slot_cmp #(
        .AW (AW),
        .TW (TW)
      ) u_cmp_rs (
        .i_valid (r_valid[k]),
        .i_a3    (r_a3[k]),
        .i_tnew  (r_tnew[k]),
        .i_reg   (i_d_rs),
        .i_tuse  (i_d_tuse_rs),
        .o_match (w_rs_match[k]),
        .o_late  (w_rs_late[k]),
        .o_ready (w_rs_ready[k])
      );

      hazard_slot_cmp #(
        .AW (AW),
        .TW (TW)
      ) u_cmp_rt (
        .i_valid (r_valid[k]),
        .i_a3    (r_a3[k]),
        .i_tnew  (r_tnew[k]),
        .i_reg   (i_d_rt),
        .i_tuse  (i_d_tuse_rt),
        .o_match (w_rt_match[k]),
        .o_late  (w_rt_late[k]),
        .o_ready (w_rt_ready[k])
      );
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Youngest-match priority pick. The loop walks from the oldest slot to the
  // youngest, so a younger match always overwrites an older one. An older
  // ready producer therefore never wins over a younger one that is not ready.
  // --------------------------------------------------------------------------
  always_comb begin
    w_rs_hit      = 1'b0;
    w_rt_hit      = 1'b0;
    w_rs_late_sel = 1'b0;
    w_rt_late_sel = 1'b0;
    w_fwd_rs      = FWD_RF;
    w_fwd_rt      = FWD_RF;
    for (int k = NSTG - 1; k >= 0; k--) begin
      if (w_rs_match[k]) begin
        w_rs_hit      = 1'b1;
        w_rs_late_sel = w_rs_late[k];
        w_fwd_rs      = w_rs_ready[k] ? 2'(k + 1) : FWD_RF;
      end
      if (w_rt_match[k]) begin
        w_rt_hit      = 1'b1;
        w_rt_late_sel = w_rt_late[k];
        w_fwd_rt      = w_rt_ready[k] ? 2'(k + 1) : FWD_RF;
      end
    end
  end

  assign w_data_stall = (i_d_rs_use && w_rs_hit && w_rs_late_sel) ||
                        (i_d_rt_use && w_rt_hit && w_rt_late_sel);

  // The start_in_E flag covers the cycle in which a freshly accepted
  // mult/div sits in E. Because of it, md_busy is correct even for a
  // zero latency.
  assign w_md_busy   = (r_md_cnt != '0) || r_md_start_e;
  assign w_md_stall  = (i_d_md_use || i_d_md_start) && w_md_busy;
  assign w_stall     = w_data_stall || w_md_stall;
  assign w_md_accept = i_d_md_start && !w_stall;

  // --------------------------------------------------------------------------
  // Shift chain: slot 0 takes the D instruction (or a bubble on stall), and
  // older slots age by one cycle with Tnew saturating at zero.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      for (int k = 0; k < NSTG; k++) begin
        r_a3[k]   <= '0;
        r_tnew[k] <= '0;
      end
    end else begin
      if (w_stall) begin
        r_valid[0] <= 1'b0;
        r_a3[0]    <= '0;
        r_tnew[0]  <= '0;
      end else begin
        r_valid[0] <= (i_d_a3 != '0);
        r_a3[0]    <= i_d_a3;
        r_tnew[0]  <= i_d_tnew;
      end
      for (int k = 1; k < NSTG; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_a3[k]    <= r_a3[k-1];
        r_tnew[k]  <= (r_tnew[k-1] == '0) ? '0 : (r_tnew[k-1] - TW'(1));
      end
    end
  end

  // --------------------------------------------------------------------------
  // MDU busy counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_md_cnt     <= '0;
      r_md_start_e <= 1'b0;
    end else if (w_md_accept) begin
      r_md_cnt     <= i_d_md_div ? C_CW'(DIV_LAT) : C_CW'(MUL_LAT);
      r_md_start_e <= 1'b1;
    end else begin
      r_md_cnt     <= (r_md_cnt != '0) ? (r_md_cnt - C_CW'(1)) : '0;
      r_md_start_e <= 1'b0;
    end
  end

  assign o_fd_stall  = w_stall;
  assign o_de_bubble = w_stall;
  assign o_fwd_rs    = w_fwd_rs;
  assign o_fwd_rt    = w_fwd_rt;
  assign o_md_busy   = w_md_busy;

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Directed-vector bench for hazard_scoreboard. Each D-stage
//               instruction is applied just after a rising edge, and the
//               combinational outputs are compared one time unit later.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_scoreboard;

  logic       clk;
  logic       reset;
  logic [4:0] d_rs, d_rt, d_a3;
  logic       d_rs_use, d_rt_use;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_md_start, d_md_div, d_md_use;
  logic       fd_stall, de_bubble, md_busy;
  logic [1:0] fwd_rs, fwd_rt;

  int n_vec;
  int n_err;
  int n_stall;

  hazard_scoreboard dut (
    .clk          (clk),
    .reset        (reset),
    .i_d_rs       (d_rs),
    .i_d_rs_use   (d_rs_use),
    .i_d_tuse_rs  (d_tuse_rs),
    .i_d_rt       (d_rt),
    .i_d_rt_use   (d_rt_use),
    .i_d_tuse_rt  (d_tuse_rt),
    .i_d_a3       (d_a3),
    .i_d_tnew     (d_tnew),
    .i_d_md_start (d_md_start),
    .i_d_md_div   (d_md_div),
    .i_d_md_use   (d_md_use),
    .o_fd_stall   (fd_stall),
    .o_de_bubble  (de_bubble),
    .o_fwd_rs     (fwd_rs),
    .o_fwd_rt     (fwd_rt),
    .o_md_busy    (md_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Present one D-stage instruction
  task automatic drive(input logic [4:0] rs, input logic rsu, input logic [1:0] tu_rs,
                       input logic [4:0] rt, input logic rtu, input logic [1:0] tu_rt,
                       input logic [4:0] a3, input logic [1:0] tnew,
                       input logic mds, input logic mdd, input logic mdu);
    d_rs = rs; d_rs_use = rsu; d_tuse_rs = tu_rs;
    d_rt = rt; d_rt_use = rtu; d_tuse_rt = tu_rt;
    d_a3 = a3; d_tnew = tnew;
    d_md_start = mds; d_md_div = mdd; d_md_use = mdu;
  endtask

  // Move to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic count_mdu_stall(input string tag, input int exp_cycles);
    n_stall = 0;
    while (fd_stall && n_stall < 40) begin
      n_stall++;
      @(posedge clk);
      #2;
    end
    check({tag, "_cycles"}, n_stall, exp_cycles);
    check({tag, "_release"}, fd_stall, 0);
    check({tag, "_busy_off"}, md_busy, 0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    clk   = 1'b0;
    reset = 1'b1;
    drive(0,0,0, 0,0,0, 0,0, 0,0,0);
    #2;
    check("rst_stall",  fd_stall,  0);
    check("rst_bubble", de_bubble, 0);
    check("rst_fwd_rs", fwd_rs,    0);
    check("rst_fwd_rt", fwd_rt,    0);
    check("rst_busy",   md_busy,   0);
    step();
    reset = 1'b0;

    // lw $1 (tnew 2) then addu $2,$1,$1 (tuse 1)
    drive(0,0,0, 0,0,0, 1,2, 0,0,0); #1;
    check("lw_nostall", fd_stall, 0);
    step(); drive(1,1,1, 1,1,1, 2,1, 0,0,0); #1;
    check("lwuse_stall",  fd_stall,  1);
    check("lwuse_bubble", de_bubble, 1);
    step(); #1;
    // lw has reached M with tnew 1: no longer too late, but not forwardable yet
    check("lwuse_go",     fd_stall, 0);
    check("lwuse_fwd_rs", fwd_rs,   0);
    check("lwuse_fwd_rt", fwd_rt,   0);
    step(); drive(1,1,0, 0,0,0, 0,0, 0,0,0); #1;
    check("lw_w_fwd_rs", fwd_rs,   3);
    check("lw_w_stall",  fd_stall, 0);

    // addu $3 (tnew 1) then beq $3,$0 (tuse 0)
    step(); drive(0,0,0, 0,0,0, 3,1, 0,0,0); #1;
    step(); drive(3,1,0, 0,1,0, 0,0, 0,0,0); #1;
    check("beq_stall",  fd_stall, 1);
    check("beq_fwd_rs", fwd_rs,   0);
    step(); #1;
    check("beq_go",     fd_stall, 0);
    check("beq_fwd_rs2", fwd_rs,  2);
    check("beq_fwd_rt", fwd_rt,   0);

    // addu $5 (tnew 1) then sw with rt tuse 2
    step(); drive(0,0,0, 0,0,0, 5,1, 0,0,0); #1;
    step(); drive(0,1,1, 5,1,2, 0,0, 0,0,0); #1;
    check("sw_nostall", fd_stall, 0);
    check("sw_fwd_rt",  fwd_rt,   0);

    // lw $4, then ori $4 (tnew 0), then a reader of $4
    step(); drive(0,0,0, 0,0,0, 4,2, 0,0,0); #1;
    step(); drive(0,0,0, 0,0,0, 4,0, 0,0,0); #1;
    step(); drive(4,1,0, 4,1,0, 0,0, 0,0,0); #1;
    check("young_fwd_rs", fwd_rs,   1);
    check("young_fwd_rt", fwd_rt,   1);
    check("young_stall",  fd_stall, 0);

    // write to $0 with tnew 2, then a reader of $0
    step(); drive(0,0,0, 0,0,0, 0,2, 0,0,0); #1;
    step(); drive(0,1,0, 0,1,0, 0,0, 0,0,0); #1;
    check("r0_stall",  fd_stall, 0);
    check("r0_fwd_rs", fwd_rs,   0);
    check("r0_fwd_rt", fwd_rt,   0);

    // div issued, mfhi next
    step(); drive(0,0,0, 0,0,0, 0,0, 1,1,1); #1;
    check("div_issue_stall", fd_stall, 0);
    check("div_issue_busy",  md_busy,  0);
    step(); drive(0,0,0, 0,0,0, 8,1, 0,0,1); #1;
    check("div_busy", md_busy, 1);
    count_mdu_stall("div", 10);

    // mult issued, mfhi next
    step(); drive(0,0,0, 0,0,0, 0,0, 1,0,1); #1;
    check("mul_issue_stall", fd_stall, 0);
    step(); drive(0,0,0, 0,0,0, 8,1, 0,0,1); #1;
    check("mul_busy", md_busy, 1);
    count_mdu_stall("mul", 5);

    // reset in the middle of a div with a lw pending
    step(); drive(0,0,0, 0,0,0, 0,0, 1,1,1); #1;
    step(); drive(0,0,0, 0,0,0, 9,2, 0,0,0); #1;
    step(); drive(9,1,0, 9,1,0, 0,0, 0,0,1); #1;
    check("pre_rst_stall", fd_stall, 1);
    check("pre_rst_busy",  md_busy,  1);
    #1 reset = 1'b1;
    #1;
    check("midrst_busy",   md_busy,  0);
    check("midrst_stall",  fd_stall, 0);
    check("midrst_bubble", de_bubble, 0);
    check("midrst_fwd_rs", fwd_rs,   0);
    check("midrst_fwd_rt", fwd_rt,   0);
    step();
    reset = 1'b0;
    #1;
    check("postrst_stall", fd_stall, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
